// File: rtl/mem_access_unit_if.sv
// Core-side request/response and RAM-side byte bus of the memory access unit.
// slave is the unit's view, master is the view of whoever drives the core and RAM.
`ifndef MXLEN
`define MXLEN 32
`endif

interface mem_access_unit_if;
   localparam int XLEN = `MXLEN;

   logic            req_valid;
   logic            req_ready;
   logic            req_store;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            exception;
   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;
   logic            load_misaligned;
   logic            store_misaligned;
   logic [XLEN-1:0] mem_addr;
   logic            mem_re;
   logic            mem_we;
   logic [7:0]      mem_wdata;
   logic [7:0]      mem_rdata;
   logic            mem_ack;

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, exception,
      input  mem_rdata, mem_ack,
      output req_ready, resp_valid, resp_rdata, load_misaligned, store_misaligned,
      output mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, exception,
      output mem_rdata, mem_ack,
      input  req_ready, resp_valid, resp_rdata, load_misaligned, store_misaligned,
      input  mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-serial load/store engine: splits LB/LH/LW/LBU/LHU/SB/SH/SW into 1-4
// little-endian byte transfers on an 8-bit RAM port, with alignment and funct3 checks.
`ifndef MXLEN
`define MXLEN 32
`endif

module mem_access_unit #(
   parameter logic [2:0] F3_LB  = 3'd0,
   parameter logic [2:0] F3_LH  = 3'd1,
   parameter logic [2:0] F3_LW  = 3'd2,
   parameter logic [2:0] F3_LBU = 3'd4,
   parameter logic [2:0] F3_LHU = 3'd5,
   parameter logic [2:0] F3_SB  = 3'd0,
   parameter logic [2:0] F3_SH  = 3'd1,
   parameter logic [2:0] F3_SW  = 3'd2
) (
   input logic              CLK,
   input logic              RST,
   mem_access_unit_if.slave bus
);
   localparam int XLEN = `MXLEN;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   state_e          state_q, state_d;
   logic            store_q, store_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [1:0]      idx_q, idx_d;
   logic            mem_re_q, mem_re_d;
   logic            mem_we_q, mem_we_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]      mem_wdata_q, mem_wdata_d;
   logic            resp_valid_q, resp_valid_d;
   logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
   logic            load_mis_q, load_mis_d;
   logic            store_mis_q, store_mis_d;

   logic [2:0]      n_req, n_cur;
   logic            resp_fire;

   // Byte count of an access; 0 marks an unsupported funct3.
   function automatic logic [2:0] byte_count(input logic store, input logic [2:0] f3);
      byte_count = 3'd0;
      if (store) begin
         if (f3 == F3_SB)      byte_count = 3'd1;
         else if (f3 == F3_SH) byte_count = 3'd2;
         else if (f3 == F3_SW) byte_count = 3'd4;
      end else begin
         if (f3 == F3_LB || f3 == F3_LBU)      byte_count = 3'd1;
         else if (f3 == F3_LH || f3 == F3_LHU) byte_count = 3'd2;
         else if (f3 == F3_LW)                 byte_count = 3'd4;
      end
   endfunction

   function automatic logic is_misaligned(input logic [2:0] n, input logic [1:0] a);
      is_misaligned = (n == 3'd2 && a[0]) || (n == 3'd4 && a != 2'b00);
   endfunction

   function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3, input logic [XLEN-1:0] w);
      extend_load = '0;
      if (f3 == F3_LB)       extend_load = XLEN'($signed(w[7:0]));
      else if (f3 == F3_LH)  extend_load = XLEN'($signed(w[15:0]));
      else if (f3 == F3_LBU) extend_load = XLEN'(w[7:0]);
      else if (f3 == F3_LHU) extend_load = XLEN'(w[15:0]);
      else if (f3 == F3_LW)  extend_load = XLEN'(w[31:0]);
   endfunction

   assign n_req = byte_count(bus.req_store, bus.req_funct3);
   assign n_cur = byte_count(store_q, funct3_q);

   // NOTE: every signal written below gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      store_d      = store_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      result_d     = result_q;
      idx_d        = idx_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      load_mis_d   = 1'b0;
      store_mis_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid && !bus.exception) begin
               store_d  = bus.req_store;
               funct3_d = bus.req_funct3;
               addr_d   = bus.req_addr;
               wdata_d  = bus.req_wdata;
               idx_d    = 2'd0;
               result_d = '0;
               if (n_req == 3'd0) begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
               end else if (is_misaligned(n_req, bus.req_addr[1:0])) begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  load_mis_d   = !bus.req_store;
                  store_mis_d  = bus.req_store;
               end else begin
                  state_d     = ACCESS;
                  mem_re_d    = !bus.req_store;
                  mem_we_d    = bus.req_store;
                  mem_addr_d  = bus.req_addr;
                  mem_wdata_d = bus.req_wdata[7:0];
               end
            end
         end

         ACCESS: begin
            if (bus.exception) begin
               state_d = IDLE;
            end else begin
               if (bus.mem_ack && !store_q) result_d[{idx_q, 3'b000} +: 8] = bus.mem_rdata;
               if (bus.mem_ack && {1'b0, idx_q} == n_cur - 3'd1) begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = store_q ? '0 : extend_load(funct3_q, result_d);
               end else begin
                  // Strobes stay up through wait states; only an ack advances the byte.
                  if (bus.mem_ack) idx_d = idx_q + 2'd1;
                  mem_re_d    = !store_q;
                  mem_we_d    = store_q;
                  mem_addr_d  = addr_q + XLEN'(idx_d);
                  mem_wdata_d = wdata_q[{idx_d, 3'b000} +: 8];
               end
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         store_q      <= 1'b0;
         funct3_q     <= 3'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
         result_q     <= '0;
         idx_q        <= 2'd0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         load_mis_q   <= 1'b0;
         store_mis_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         store_q      <= store_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         result_q     <= result_d;
         idx_q        <= idx_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         load_mis_q   <= load_mis_d;
         store_mis_q  <= store_mis_d;
      end
   end

   // An exception during DONE swallows the completion pulse in the same cycle.
   assign resp_fire            = resp_valid_q && !bus.exception;
   assign bus.req_ready        = (state_q == IDLE) && !bus.exception;
   assign bus.resp_valid       = resp_fire;
   assign bus.resp_rdata       = resp_fire ? resp_rdata_q : '0;
   assign bus.load_misaligned  = resp_fire && load_mis_q;
   assign bus.store_misaligned = resp_fire && store_mis_q;
   assign bus.mem_addr         = mem_addr_q;
   assign bus.mem_re           = mem_re_q;
   assign bus.mem_we           = mem_we_q;
   assign bus.mem_wdata        = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level RAM responder with
// configurable wait states plus a request-level reference model.
`ifndef MXLEN
`define MXLEN 32
`endif

module tb_mem_access_unit;
   logic CLK = 1'b0;
   logic RST;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   mem_access_unit_if bus ();
   mem_access_unit dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
      logic        we;
      int          first;
      int          cycles;
   } xfer_t;

   typedef struct {
      int          at;
      logic [31:0] rdata;
      logic        lm;
      logic        sm;
   } resp_t;

   logic [7:0] ram [0:1023];
   xfer_t      byte_q[$];
   resp_t      resp_q[$];
   xfer_t      cur;
   bit         in_byte = 0;
   bit         stray_ack = 0;
   int         wait_cycles = 0;
   int         strobe_cnt = 0;

   // RAM responder and bus monitor, sampled on the falling edge.
   always @(negedge CLK) begin
      checks++;
      if (!bus.resp_valid && (bus.resp_rdata !== 32'd0 || bus.load_misaligned !== 1'b0 ||
                              bus.store_misaligned !== 1'b0)) begin
         errors++;
         $display("FAIL idle_resp_outputs: rdata=%h lm=%b sm=%b want 0", bus.resp_rdata,
                  bus.load_misaligned, bus.store_misaligned);
      end
      if (bus.resp_valid === 1'b1)
         resp_q.push_back('{cyc, bus.resp_rdata, bus.load_misaligned, bus.store_misaligned});
      if (bus.mem_re === 1'b1 || bus.mem_we === 1'b1) begin
         strobe_cnt++;
         if (!in_byte) begin
            cur = '{bus.mem_addr, bus.mem_wdata, bus.mem_we, cyc, 1};
            in_byte = 1;
         end else begin
            checks++;
            if (bus.mem_addr !== cur.addr || bus.mem_we !== cur.we || bus.mem_wdata !== cur.data) begin
               errors++;
               $display("FAIL hold_stable: addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                        bus.mem_addr, bus.mem_we, bus.mem_wdata, cur.addr, cur.we, cur.data);
            end
            cur.cycles++;
         end
         if (cur.cycles == wait_cycles + 1) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = ram[bus.mem_addr[9:0]];
            if (bus.mem_we === 1'b1) ram[bus.mem_addr[9:0]] = bus.mem_wdata;
            byte_q.push_back(cur);
            in_byte = 0;
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'h00;
         end
      end else begin
         in_byte       = 0;
         bus.mem_ack   = stray_ack;
         bus.mem_rdata = 8'hEE;
      end
   end

   function automatic int nbytes_of(input bit st, input logic [2:0] f3);
      if (st) begin
         case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            default: return 0;
         endcase
      end
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2: return 4;
         default: return 0;
      endcase
   endfunction

   // Issue one request, then check response timing/value and every byte transfer against the model.
   task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int waits, input string name,
                         output logic [31:0] got_rd);
      int n, t, exp_at, nx;
      bit mis;
      longint v;
      logic [31:0] exp_rd;
      n = nbytes_of(st, f3);
      mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
      nx = mis ? 0 : n;
      exp_rd = 32'd0;
      if (!st && nx != 0) begin
         v = 0;
         for (int i = nx - 1; i >= 0; i--) v = v * 256 + longint'(ram[10'(addr + 32'(i))]);
         if (f3 == 3'd0 && v >= 128) v = v - 256;
         if (f3 == 3'd1 && v >= 32768) v = v - 65536;
         exp_rd = v[31:0];
      end
      exp_at = (nx == 0) ? 1 : 1 + nx * (waits + 1);
      byte_q.delete();
      resp_q.delete();
      strobe_cnt  = 0;
      wait_cycles = waits;
      got_rd      = 32'hDEADBEEF;

      @(posedge CLK); #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b want 1", name, bus.req_ready);
      end
      bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wd;
      t = cyc;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
      bus.req_funct3 = 3'($urandom); bus.req_store = 1'($urandom);
      for (int k = 0; k < 100 && resp_q.size() == 0; k++) @(posedge CLK);
      repeat (3) @(posedge CLK);
      #1;

      checks++;
      if (resp_q.size() != 1) begin
         errors++;
         $display("FAIL %s resp_count: got %0d want 1", name, resp_q.size());
      end else begin
         got_rd = resp_q[0].rdata;
         checks++;
         if (resp_q[0].at != t + exp_at) begin
            errors++;
            $display("FAIL %s resp_cycle: got T+%0d want T+%0d", name, resp_q[0].at - t, exp_at);
         end
         checks++;
         if (resp_q[0].rdata !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata: got %h want %h", name, resp_q[0].rdata, exp_rd);
         end
         checks++;
         if (resp_q[0].lm !== (mis && !st) || resp_q[0].sm !== (mis && st)) begin
            errors++;
            $display("FAIL %s misaligned: got lm=%b sm=%b want lm=%b sm=%b", name,
                     resp_q[0].lm, resp_q[0].sm, mis && !st, mis && st);
         end
      end
      checks++;
      if (byte_q.size() != nx || strobe_cnt != nx * (waits + 1)) begin
         errors++;
         $display("FAIL %s strobes: got %0d bytes/%0d cycles want %0d/%0d", name,
                  byte_q.size(), strobe_cnt, nx, nx * (waits + 1));
      end else begin
         for (int i = 0; i < nx; i++) begin
            checks++;
            if (byte_q[i].addr !== addr + 32'(i) || byte_q[i].we !== st ||
                byte_q[i].first != t + 1 + i * (waits + 1) || byte_q[i].cycles != waits + 1 ||
                (st && byte_q[i].data !== 8'((wd >> (8 * i)) & 32'hFF))) begin
               errors++;
               $display("FAIL %s byte%0d: got addr=%h we=%b data=%h at T+%0d x%0d want addr=%h we=%b at T+%0d x%0d",
                        name, i, byte_q[i].addr, byte_q[i].we, byte_q[i].data, byte_q[i].first - t,
                        byte_q[i].cycles, addr + 32'(i), st, 1 + i * (waits + 1), waits + 1);
            end
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.exception = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 ||
          bus.mem_addr !== 32'd0 || bus.mem_wdata !== 8'd0 || bus.resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ready=%b re=%b we=%b addr=%h wd=%h rv=%b want 1,0,0,0,0,0",
                  bus.req_ready, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.resp_valid);
      end
      RST = 1'b0;
      resp_q.delete(); strobe_cnt = 0; stray_ack = 1;
      repeat (4) @(posedge CLK);
      #1;
      stray_ack = 0;
      checks++;
      if (strobe_cnt != 0 || resp_q.size() != 0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL stray_ack: got strobes=%0d resps=%0d ready=%b want 0,0,1",
                  strobe_cnt, resp_q.size(), bus.req_ready);
      end
   endtask

   task automatic test_lw_directed();
      logic [31:0] rd;
      ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
      run_op(1'b0, 3'd2, 32'h100, 32'd0, 0, "lw_0x100", rd);
      checks++;
      if (rd !== 32'h12345678) begin
         errors++;
         $display("FAIL lw_value: got %h want 12345678", rd);
      end
   endtask

   task automatic test_lb_lbu();
      logic [31:0] rd;
      ram[10'h7] = 8'h80;
      run_op(1'b0, 3'd0, 32'h7, 32'd0, 0, "lb_0x7", rd);
      checks++;
      if (rd !== 32'hFFFFFF80) begin
         errors++;
         $display("FAIL lb_sign: got %h want ffffff80", rd);
      end
      run_op(1'b0, 3'd4, 32'h7, 32'd0, 1, "lbu_0x7", rd);
      checks++;
      if (rd !== 32'h00000080) begin
         errors++;
         $display("FAIL lbu_zero: got %h want 00000080", rd);
      end
   endtask

   task automatic test_misaligned_unsupported();
      logic [31:0] rd;
      run_op(1'b1, 3'd1, 32'h21, 32'h5555, 0, "sh_mis", rd);
      run_op(1'b0, 3'd2, 32'h102, 32'd0, 0, "lw_mis", rd);
      run_op(1'b0, 3'd3, 32'h10, 32'd0, 0, "ld_unsup", rd);
      run_op(1'b1, 3'd5, 32'h10, 32'h1234, 0, "st_unsup", rd);
   endtask

   task automatic test_sw_waits();
      logic [31:0] rd;
      run_op(1'b1, 3'd2, 32'h40, 32'hA1B2C3D4, 2, "sw_waits", rd);
      checks++;
      if ({ram[10'h43], ram[10'h42], ram[10'h41], ram[10'h40]} !== 32'hA1B2C3D4) begin
         errors++;
         $display("FAIL sw_ram: got %h%h%h%h want a1b2c3d4", ram[10'h43], ram[10'h42], ram[10'h41], ram[10'h40]);
      end
   endtask

   task automatic test_exception();
      byte_q.delete(); resp_q.delete(); wait_cycles = 0;
      @(posedge CLK); #1;
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h200;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
      for (int k = 0; k < 20 && byte_q.size() < 1; k++) @(posedge CLK);
      #1;
      bus.exception = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL exc_ready_low: got %b want 0", bus.req_ready);
      end
      @(posedge CLK); #1;
      checks++;
      if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin
         errors++;
         $display("FAIL exc_strobes: got re=%b we=%b want 0,0", bus.mem_re, bus.mem_we);
      end
      bus.exception = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL exc_ready: got %b want 1", bus.req_ready);
      end
      // Abort during DONE of a misaligned store must also swallow the pulse.
      @(posedge CLK); #1;
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'd1; bus.req_addr = 32'h21;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0; bus.exception = 1'b1;
      @(posedge CLK); #1;
      bus.exception = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      checks++;
      if (resp_q.size() != 0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL exc_no_resp: got resps=%0d ready=%b want 0,1", resp_q.size(), bus.req_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      byte_q.delete(); resp_q.delete(); wait_cycles = 2;
      @(posedge CLK); #1;
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'd2;
      bus.req_addr = 32'h80; bus.req_wdata = 32'h11223344;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
      for (int k = 0; k < 40 && byte_q.size() < 1; k++) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      checks++;
      if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.resp_valid !== 1'b0 || bus.mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid: re=%b we=%b ready=%b rv=%b addr=%h want 0,0,1,0,0",
                  bus.mem_re, bus.mem_we, bus.req_ready, bus.resp_valid, bus.mem_addr);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (6) @(posedge CLK);
      #1;
      checks++;
      if (resp_q.size() != 0 || ram[10'h80] !== 8'h44) begin
         errors++;
         $display("FAIL rst_mid_after: got resps=%0d ram80=%h want 0,44", resp_q.size(), ram[10'h80]);
      end
      run_op(1'b0, 3'd5, 32'h80, 32'd0, 0, "lhu_after_rst", rd);
   endtask

   task automatic test_random();
      logic [31:0] rd;
      for (int i = 0; i < 30; i++)
         run_op(1'($urandom), 3'($urandom), 32'($urandom_range(0, 32'h3F8)), $urandom,
                int'($urandom_range(0, 2)), "random", rd);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
      test_reset();
      test_lw_directed();
      test_lb_lbu();
      test_misaligned_unsupported();
      test_sw_waits();
      test_exception();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end
endmodule
